// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 streaming multiplexer.
package stream_mux_pkg;

   localparam int unsigned MODE_SEL = 0;
   localparam int unsigned MODE_RR  = 1;

   // Cyclic increment: n-1 wraps to 0.
   function automatic int unsigned inc_mod(input int unsigned idx, input int unsigned n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin priority search starting at ptr.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic              gnt_valid,
   output logic [SEL_W-1:0]  gnt_idx
);

   int unsigned idx;

   // Walk ptr, ptr+1, ... (wrapping) and take the first requester.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 32'(ptr);
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SEL_W'(idx);
         end
         idx = inc_mod(idx, NUM_CH);
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a one-entry registered output.
// in_ready depends combinationally on out_ready by design.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_CH),
   parameter int unsigned MODE   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   input  logic                    out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   logic             load_en_c;
   logic             gnt_valid_c;
   logic [SEL_W-1:0] gnt_idx_c;
   logic             xfer_c;

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic unused_sel;
         assign unused_sel = ^sel;

         rr_arbiter #(
            .NUM_CH (NUM_CH),
            .SEL_W  (SEL_W)
         ) u_arb (
            .req       (in_valid),
            .ptr       (ptr_q),
            .gnt_valid (gnt_valid_c),
            .gnt_idx   (gnt_idx_c)
         );
      end else begin : g_sel
         // External select; an out-of-range sel never grants.
         always_comb begin
            gnt_valid_c = 1'b0;
            gnt_idx_c   = sel;
            if (32'(sel) < NUM_CH) begin
               gnt_valid_c = in_valid[sel];
            end
         end
      end
   endgenerate

   assign load_en_c = !out_valid_q || out_ready;
   assign xfer_c    = load_en_c && gnt_valid_c;
   assign in_ready  = (rst_n && xfer_c) ? (NUM_CH'(1) << gnt_idx_c) : '0;

   // Output register load/drain and round-robin pointer advance.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (xfer_c) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[32'(gnt_idx_c) * WIDTH +: WIDTH];
         out_ch_d    = gnt_idx_c;
         if (MODE == MODE_RR) begin
            ptr_d = SEL_W'(inc_mod(32'(gnt_idx_c), NUM_CH));
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised bench: four mux configurations checked against a behavioural model.
module tb_stream_mux_rr;
   import stream_mux_pkg::*;

   localparam int unsigned ND = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]   iv   [ND];
   logic [127:0] idat [ND];
   logic [3:0]   ir   [ND];
   logic         ov   [ND];
   logic [31:0]  od   [ND];
   logic [1:0]   och  [ND];
   logic [1:0]   sel;
   logic         out_ready;
   logic [2:0]   ir_rr3, ir_sel3;

   // d0: round-robin 4ch, d1: round-robin 3ch, d2: select 4ch, d3: select 3ch
   stream_mux_rr #(.WIDTH(32), .NUM_CH(4), .MODE(MODE_RR)) u_rr4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir[0]),
      .sel(sel), .out_valid(ov[0]), .out_data(od[0]), .out_ch(och[0]), .out_ready(out_ready));
   stream_mux_rr #(.WIDTH(32), .NUM_CH(3), .MODE(MODE_RR)) u_rr3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1][2:0]), .in_data(idat[1][95:0]), .in_ready(ir_rr3),
      .sel(sel), .out_valid(ov[1]), .out_data(od[1]), .out_ch(och[1]), .out_ready(out_ready));
   stream_mux_rr #(.WIDTH(32), .NUM_CH(4), .MODE(MODE_SEL)) u_sel4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(idat[2]), .in_ready(ir[2]),
      .sel(sel), .out_valid(ov[2]), .out_data(od[2]), .out_ch(och[2]), .out_ready(out_ready));
   stream_mux_rr #(.WIDTH(32), .NUM_CH(3), .MODE(MODE_SEL)) u_sel3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[3][2:0]), .in_data(idat[3][95:0]), .in_ready(ir_sel3),
      .sel(sel), .out_valid(ov[3]), .out_data(od[3]), .out_ch(och[3]), .out_ready(out_ready));

   assign ir[1] = {1'b0, ir_rr3};
   assign ir[3] = {1'b0, ir_sel3};

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // Reference model state
   bit          mv   [ND];
   logic [31:0] md   [ND];
   int unsigned mch  [ND];
   int unsigned mptr [ND];
   bit          eg_v [ND];
   int unsigned eg   [ND];
   logic [3:0]  hold [ND];
   logic [31:0] hdat [ND][4];

   // Phase knobs
   logic [3:0]  pm4, pm3;
   int unsigned pv, pr;
   bit          a0;
   int          sel_fix;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned nch_of(input int unsigned d);
      return (d % 2 == 0) ? 4 : 3;
   endfunction

   function automatic bit rr_of(input int unsigned d);
      return d < 2;
   endfunction

   task automatic model_reset();
      for (int unsigned d = 0; d < ND; d++) begin
         mv[d] = 1'b0; md[d] = '0; mch[d] = 0; mptr[d] = 0;
      end
   endtask

   // One clock cycle: check outputs, drive inputs, check in_ready, advance model.
   task automatic step();
      @(negedge clk);
      for (int unsigned d = 0; d < ND; d++) begin
         chk($sformatf("d%0d out_valid", d), 32'(ov[d]), 32'(mv[d]));
         chk($sformatf("d%0d out_data", d), od[d], md[d]);
         chk($sformatf("d%0d out_ch", d), 32'(och[d]), mch[d]);
      end
      out_ready = ($urandom_range(99) < pr);
      sel = (sel_fix < 0) ? 2'($urandom_range(3)) : 2'(sel_fix);
      for (int unsigned d = 0; d < ND; d++) begin
         logic [3:0] m;
         m = (nch_of(d) == 4) ? pm4 : pm3;
         for (int unsigned c = 0; c < nch_of(d); c++) begin
            if (!hold[d][c]) begin
               iv[d][c] = m[c] && ($urandom_range(99) < pv);
               idat[d][c*32 +: 32] = a0 ? 32'hA0 + c : 32'($urandom);
            end
         end
      end
      #1;
      for (int unsigned d = 0; d < ND; d++) begin
         int unsigned n;
         n = nch_of(d);
         eg_v[d] = 1'b0;
         eg[d]   = 0;
         if (rst_n && (!mv[d] || out_ready)) begin
            if (rr_of(d)) begin
               for (int unsigned k = 0; k < n; k++) begin
                  int unsigned c;
                  c = (mptr[d] + k) % n;
                  if (!eg_v[d] && iv[d][c]) begin eg_v[d] = 1'b1; eg[d] = c; end
               end
            end else if (32'(sel) < n && iv[d][sel]) begin
               eg_v[d] = 1'b1;
               eg[d]   = 32'(sel);
            end
         end
         chk($sformatf("d%0d in_ready", d), 32'(ir[d]), eg_v[d] ? (32'd1 << eg[d]) : 32'd0);
      end
      @(posedge clk);
      for (int unsigned d = 0; d < ND; d++) begin
         int unsigned n;
         n = nch_of(d);
         for (int unsigned c = 0; c < n; c++) begin
            if (hold[d][c]) begin
               assert (iv[d][c] && idat[d][c*32 +: 32] == hdat[d][c])
                  else $error("protocol: d%0d ch%0d withdrew or changed before transfer", d, c);
            end
         end
         if (rst_n) begin
            if (eg_v[d]) begin
               mv[d]  = 1'b1;
               md[d]  = idat[d][eg[d]*32 +: 32];
               mch[d] = eg[d];
               if (rr_of(d)) mptr[d] = (eg[d] + 1) % n;
            end else if (mv[d] && out_ready) begin
               mv[d] = 1'b0;
            end
         end
         for (int unsigned c = 0; c < n; c++) begin
            hold[d][c] = iv[d][c] && !(eg_v[d] && eg[d] == c);
            hdat[d][c] = idat[d][c*32 +: 32];
         end
      end
   endtask

   task automatic run(input logic [3:0] m4, input logic [3:0] m3, input int unsigned v,
                      input int unsigned r, input bit use_a0, input int s, input int unsigned cyc);
      pm4 = m4; pm3 = m3; pv = v; pr = r; a0 = use_a0; sel_fix = s;
      for (int unsigned i = 0; i < cyc; i++) step();
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      sel = '0;
      for (int unsigned d = 0; d < ND; d++) begin
         iv[d] = '0; idat[d] = '0; hold[d] = '0; eg_v[d] = 1'b0; eg[d] = 0;
         for (int unsigned c = 0; c < 4; c++) hdat[d][c] = '0;
      end
      model_reset();
      #3;
      for (int unsigned d = 0; d < ND; d++) begin
         chk($sformatf("d%0d reset out_valid", d), 32'(ov[d]), 32'd0);
         chk($sformatf("d%0d reset out_data", d), od[d], 32'd0);
         chk($sformatf("d%0d reset out_ch", d), 32'(och[d]), 32'd0);
         chk($sformatf("d%0d reset in_ready", d), 32'(ir[d]), 32'd0);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;

      // fairness, then skip/wrap
      run(4'b1111, 4'b0111, 100, 100, 1'b1, -1, 16);
      run(4'b1001, 4'b0110, 100, 100, 1'b0, -1, 12);
      // backpressure stall then release
      run(4'b1111, 4'b0111, 100,   0, 1'b0,  2, 6);
      run(4'b1111, 4'b0111, 100, 100, 1'b0,  2, 6);
      // external select: hit, miss, out of range for the 3-channel case
      run(4'b0100, 4'b0100, 100, 100, 1'b0,  2, 6);
      run(4'b0100, 4'b0100, 100, 100, 1'b0,  1, 6);
      run(4'b1111, 4'b0111, 100, 100, 1'b0,  3, 6);
      // drain to empty
      run(4'b0010, 4'b0010, 100, 100, 1'b0,  1, 1);
      run(4'b0000, 4'b0000,   0, 100, 1'b0,  1, 6);
      // random traffic
      run(4'b1111, 4'b0111,  50,  60, 1'b0, -1, 400);
      // reset mid-stream
      run(4'b1111, 4'b0111, 100, 100, 1'b1, -1, 5);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int unsigned d = 0; d < ND; d++) begin
         chk($sformatf("d%0d midreset out_valid", d), 32'(ov[d]), 32'd0);
         chk($sformatf("d%0d midreset in_ready", d), 32'(ir[d]), 32'd0);
      end
      run(4'b1111, 4'b0111, 100, 100, 1'b1, -1, 2);
      #2 rst_n = 1'b1;
      run(4'b1111, 4'b0111, 100, 100, 1'b1, -1, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N:1 streaming multiplexer; successor to the core's 2:1 combinational data-select mux.
- Arbitrates NUM_CH valid/ready input channels onto one registered output channel.
- Selection is either by external select (MODE 0) or by round-robin arbitration (MODE 1).
- Used where several producers share one datapath consumer, e.g. writeback or memory-request merging.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 4, number of input channels (≥2; non-power-of-two legal).
- SEL_W, $clog2(NUM_CH), width of select and channel-ID fields.
- MODE, 1, 0 = external select, 1 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel valid.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NUM_CH  per-channel accept; at most one bit high.
- sel  in  SEL_W  channel select; used in MODE 0 only.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered data.
- out_ch  out  SEL_W  source channel of out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. Any in-flight beat is discarded. All in_ready=0 while rst_n is low.
- Output stage is a one-entry register.
  - load_en = !out_valid || out_ready.
  - Full throughput: one beat per cycle when out_ready is held high.
- Grant (combinational):
  - MODE 0: grant = sel when sel < NUM_CH and in_valid[sel]=1; otherwise no grant. An out-of-range sel never grants.
  - MODE 1: grant = first i with in_valid[i]=1, searching cyclically from ptr (ptr, ptr+1, … wrapping at NUM_CH). No grant if all in_valid=0.
- in_ready[i] = load_en && grant_valid && (i == grant). in_ready depends combinationally on out_ready; this is intentional and is documented for integrators.
- Transfer on channel i = in_valid[i] && in_ready[i]. On that clock edge:
  - out_data <= in_data[i], out_ch <= i, out_valid <= 1.
  - MODE 1 only: ptr <= (i == NUM_CH-1) ? 0 : i+1.
- If out_valid && out_ready and there is no transfer: out_valid <= 0. out_data and out_ch keep their last values.
- Stall (out_valid && !out_ready): out_valid, out_data and out_ch are held stable; all in_ready=0; ptr is unchanged.
- Latency: input transfer at edge N → out_valid visible after edge N, i.e. one cycle.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one, with no bubble.
- ptr never changes in MODE 0. In MODE 1, ptr changes only on a transfer.
- in_valid withdrawn by a producer before its transfer: tolerated, with no side effect. Producers must not do this; an assertion in the bench flags it.
- Fairness (MODE 1): with all channels continuously valid and out_ready=1, each channel is granted exactly once per NUM_CH cycles.

Decomposition:
- Shared package stream_mux_pkg:
  - MODE_SEL=0, MODE_RR=1 constants.
  - Function for cyclic increment modulo NUM_CH.
- One sub-module, rr_arbiter: combinational pointer-based priority search.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Instantiated only when MODE=1.
- Output register and handshake logic live in the top module.

Test Plan:
- Reset mid-stream: MODE 1, NUM_CH=4, all valid, out_ready=1, assert rst_n=0 mid-cycle → out_valid=0 immediately, in_ready=0; after release the first grant is ch0.
- Round-robin fairness: MODE 1, in_valid=4'b1111, out_ready=1, in_data[i]=32'hA0+i → out_ch sequence 0,1,2,3,0,1… and out_data matches, one beat per cycle.
- Skip and wrap: MODE 1, in_valid=4'b1001, ptr=0 → grants 0,3,0,3. Repeat with NUM_CH=3, in_valid=3'b110 → grants 1,2,1,2 (wrap from 2 to 0).
- Backpressure: hold out_ready=0 for 5 cycles after a load of 32'hDEADBEEF from ch2 → out_data/out_ch stable, in_ready=0, ptr unchanged. Release → that beat drains, and the next grant is ch3 (if valid) in the same cycle.
- MODE 0 select: sel=2, in_valid=4'b0100 → transfer from ch2. sel=1 with in_valid[1]=0 → no transfer, out_valid drops after drain. NUM_CH=3 with sel=3 → never grants.
- Drain to empty: single beat from ch1, no further valid, out_ready=1 → out_valid high for exactly one cycle, then 0, with out_data retained.
